if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch pipeline. It sits directly upstream of `id_stage`. It keeps the fetch PC and issues one instruction request at a time on the SRAM-like `inst_sram` interface. It delivers `{pc, inst}` to ID over the valid/allowin handshake and redirects on the branch bus that ID drives back. The block buffers one returned instruction while ID stalls, and discards in-flight fetches that a taken branch has made stale.

---
 rtl/if_stage_pkg.sv | 32 +++
 rtl/if_stage.sv | 153 +++++++++++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and widths for the LoongArch instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned IF_TO_ID_WD = 64;
  localparam int unsigned ID_TO_IF_WD = 34;
  localparam int unsigned PC_WD       = 32;
  localparam int unsigned INST_WD     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_taken_cancel;
  } id_to_if_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_to_id_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding inst_sram read, one-entry hold buffer,
// branch redirect with stale-fetch discard. Optional macro: IF_BR_SUSPEND_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_allowin,
  output logic                   if_to_id_valid,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  input  logic [ID_TO_IF_WD-1:0] id_to_if_bus,
  output logic                   inst_sram_req,
  output logic                   inst_sram_wr,
  output logic [1:0]             inst_sram_size,
  output logic [3:0]             inst_sram_wstrb,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        discard_q, discard_d;

  id_to_if_t   br;
  if_to_id_t   out_bus;
  logic        out_valid;
  logic        suspend;
  logic        req;
  logic        addr_hs;

  assign br = id_to_if_t'(id_to_if_bus);

`ifdef IF_BR_SUSPEND_EN
  // Branch resolved but ID stalled: hold off the sequential fetch it would waste.
  assign suspend = br.br_taken & ~br.br_taken_cancel;
`else
  logic unused_br_taken;
  assign unused_br_taken = br.br_taken;
  assign suspend         = 1'b0;
`endif

  assign req     = ~reset & (state_q == S_REQ) & ~suspend;
  assign addr_hs = req & inst_sram_addr_ok;

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    inst_buf_d = inst_buf_q;
    discard_d  = discard_q;
    out_valid  = 1'b0;
    out_bus    = '0;

    unique case (state_q)
      S_REQ: begin
        if (addr_hs) begin
          if_pc_d    = fetch_pc_q;
          fetch_pc_d = next_seq_pc(fetch_pc_q);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (id_allowin) begin
            out_valid = 1'b1;
            out_bus   = '{pc: if_pc_q, inst: inst_sram_rdata};
            state_d   = S_REQ;
          end else begin
            inst_buf_d = inst_sram_rdata;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        out_bus   = '{pc: if_pc_q, inst: inst_buf_q};
        if (id_allowin) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect overrides everything: nothing reaches ID, in-flight data is stale.
    if (br.br_taken_cancel) begin
      fetch_pc_d = br.br_target;
      out_valid  = 1'b0;
      out_bus    = '0;
      unique case (state_q)
        S_REQ: begin
          if (addr_hs) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            state_d    = S_REQ;
            discard_d  = 1'b0;
            inst_buf_d = inst_buf_q;
          end else begin
            discard_d = 1'b1;
          end
        end
        S_HOLD: begin
          state_d = S_REQ;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= '0;
      inst_buf_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      inst_buf_q <= inst_buf_d;
      discard_q  <= discard_d;
    end
  end

  assign if_to_id_valid  = out_valid;
  assign if_to_id_bus    = IF_TO_ID_WD'(out_bus);
  assign inst_sram_req   = req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: inputs driven on negedge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_allowin = 1'b0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [33:0] id_to_if_bus = '0;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .id_allowin       (id_allowin),
    .if_to_id_valid   (if_to_id_valid),
    .if_to_id_bus     (if_to_id_bus),
    .id_to_if_bus     (id_to_if_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        allowin;
    logic        cancel;
    logic [31:0] target;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_bus;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic allowin, input logic cancel,
                     input logic [31:0] target, input logic addr_ok, input logic data_ok,
                     input logic [31:0] rdata, input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_valid, input logic [63:0] exp_bus);
    vec_t v;
    v.rst = rst; v.allowin = allowin; v.cancel = cancel; v.target = target;
    v.addr_ok = addr_ok; v.data_ok = data_ok; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid; v.exp_bus = exp_bus;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br_taken, input logic cancel, input logic [31:0] target,
                       input logic allowin, input logic addr_ok, input logic data_ok,
                       input logic [31:0] rdata);
    id_to_if_bus      = {br_taken, target, cancel};
    id_allowin        = allowin;
    inst_sram_addr_ok = addr_ok;
    inst_sram_data_ok = data_ok;
    inst_sram_rdata   = rdata;
  endtask

  localparam logic [31:0] RP = 32'h1c00_0000;
`ifdef IF_BR_SUSPEND_EN
  localparam logic SUSP_REQ = 1'b0;
`else
  localparam logic SUSP_REQ = 1'b1;
`endif

  initial begin
    // rst allow cancel target addr_ok data_ok rdata | req addr valid bus
    // free-running fetch
    add(0,1,0,0,1,1,32'hAAAA0001, 1,RP,            0,64'h0);
    add(0,1,0,0,1,1,32'hAAAA0001, 0,RP+4,          1,{RP,32'hAAAA0001});
    add(0,1,0,0,1,1,32'hAAAA0002, 1,RP+4,          0,64'h0);
    add(0,1,0,0,1,1,32'hAAAA0002, 0,RP+8,          1,{RP+32'd4,32'hAAAA0002});
    add(0,1,0,0,1,1,32'hAAAA0003, 1,RP+8,          0,64'h0);
    // reset mid-transaction (S_WAIT)
    add(1,1,0,0,1,1,32'h0,        0,RP,            0,64'h0);
    // ID stall around data_ok
    add(0,0,0,0,1,0,32'h0,        1,RP,            0,64'h0);
    add(0,0,0,0,0,0,32'h0,        0,RP+4,          0,64'h0);
    add(0,0,0,0,0,1,32'h02800421, 0,RP+4,          0,64'h0);
    add(0,0,0,0,1,0,32'h0,        0,RP+4,          1,{RP,32'h02800421});
    add(0,0,0,0,1,0,32'h0,        0,RP+4,          1,{RP,32'h02800421});
    add(0,0,0,0,1,0,32'h0,        0,RP+4,          1,{RP,32'h02800421});
    add(0,1,0,0,0,0,32'h0,        0,RP+4,          1,{RP,32'h02800421});
    add(0,1,0,0,0,0,32'h0,        1,RP+4,          0,64'h0);
    // cancel in S_WAIT before data_ok
    add(0,1,0,0,1,0,32'h0,        1,RP+4,          0,64'h0);
    add(0,1,1,32'h1c000100,0,0,0, 0,RP+8,          0,64'h0);
    add(0,1,0,0,0,1,32'hDEAD0001, 0,32'h1c000100,  0,64'h0);
    add(0,1,0,0,1,0,32'h0,        1,32'h1c000100,  0,64'h0);
    add(0,1,0,0,0,1,32'h11110000, 0,32'h1c000104,  1,{32'h1c000100,32'h11110000});
    // cancel coincident with addr_ok
    add(0,1,1,32'h1c000200,1,0,0, 1,32'h1c000104,  0,64'h0);
    add(0,1,0,0,0,1,32'hDEAD0002, 0,32'h1c000200,  0,64'h0);
    add(0,1,0,0,1,0,32'h0,        1,32'h1c000200,  0,64'h0);
    add(0,1,0,0,0,1,32'h22220000, 0,32'h1c000204,  1,{32'h1c000200,32'h22220000});
    // cancel coincident with data_ok
    add(0,1,0,0,1,0,32'h0,        1,32'h1c000204,  0,64'h0);
    add(0,1,1,32'h1c000300,0,1,32'hBAD00BAD, 0,32'h1c000208, 0,64'h0);
    // cancel in S_REQ without addr_ok: address moves next cycle
    add(0,1,1,32'h1c000400,0,0,0, 1,32'h1c000300,  0,64'h0);
    add(0,1,0,0,0,0,32'h0,        1,32'h1c000400,  0,64'h0);
    // cancel in S_HOLD abandons the buffer
    add(0,1,0,0,1,0,32'h0,        1,32'h1c000400,  0,64'h0);
    add(0,0,0,0,0,1,32'h33330000, 0,32'h1c000404,  0,64'h0);
    add(0,0,1,32'h1c000500,0,0,0, 0,32'h1c000404,  0,64'h0);
    add(0,1,0,0,0,0,32'h0,        1,32'h1c000500,  0,64'h0);
    // 32-bit PC wrap
    add(0,1,1,32'hFFFFFFFC,0,0,0, 1,32'h1c000500,  0,64'h0);
    add(0,1,0,0,1,0,32'h0,        1,32'hFFFFFFFC,  0,64'h0);
    add(0,1,0,0,0,1,32'h44440000, 0,32'h00000000,  1,{32'hFFFFFFFC,32'h44440000});
    add(0,1,0,0,0,0,32'h0,        1,32'h00000000,  0,64'h0);
    // reset again mid-transaction, then req on first cycle after release
    add(0,1,0,0,1,0,32'h0,        1,32'h00000000,  0,64'h0);
    add(1,1,0,0,0,0,32'h0,        0,RP,            0,64'h0);
    add(0,1,0,0,0,0,32'h0,        1,RP,            0,64'h0);

    // reset values
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   64'(inst_sram_req),  64'h0);
    chk("rst_valid", 64'(if_to_id_valid), 64'h0);
    chk("rst_bus",   if_to_id_bus,        64'h0);
    chk("rst_addr",  64'(inst_sram_addr), 64'(RP));
    chk("const_wr",    64'(inst_sram_wr),    64'h0);
    chk("const_size",  64'(inst_sram_size),  64'h2);
    chk("const_wstrb", 64'(inst_sram_wstrb), 64'h0);
    chk("const_wdata", 64'(inst_sram_wdata), 64'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(1'b0, vecs[i].cancel, vecs[i].target, vecs[i].allowin,
            vecs[i].addr_ok, vecs[i].data_ok, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i),   64'(inst_sram_req),  64'(vecs[i].exp_req));
      chk($sformatf("v%0d_addr", i),  64'(inst_sram_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_valid", i), 64'(if_to_id_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_bus", i),   if_to_id_bus,        vecs[i].exp_bus);
    end

    // br_taken held 3 cycles while in S_REQ, then the cancel pulse
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h1c000600, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("susp%0d_req", k),  64'(inst_sram_req),  64'(SUSP_REQ));
      chk($sformatf("susp%0d_addr", k), 64'(inst_sram_addr), 64'(RP));
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h1c000600, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("susp_cancel_req",   64'(inst_sram_req),  64'h1);
    chk("susp_cancel_valid", 64'(if_to_id_valid), 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("susp_after_req",  64'(inst_sram_req),  64'h1);
    chk("susp_after_addr", 64'(inst_sram_addr), 64'h1c000600);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h55550000);
    #1;
    chk("susp_deliver_valid", 64'(if_to_id_valid), 64'h1);
    chk("susp_deliver_bus",   if_to_id_bus,        {32'h1c000600, 32'h55550000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
